// File: rtl/gate_lut_arbiter.sv
// gate_lut_arbiter
// Shares a single LUT-style 2-input gate evaluator between N_REQ requesters.
// A round-robin scan picks one pending request, its 4-bit truth table is
// steered through a 4:1 mux indexed by {a,b}, and the registered result is
// returned with the owner's ID on a valid/ready response channel.
// Only one request is ever in flight, so the block alternates between
// accepting (IDLE) and presenting a result (RESP).

module gate_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_a,
    input  logic [N_REQ-1:0]     req_b,
    input  logic [4*N_REQ-1:0]   req_func,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_out,
    input  logic                 resp_ready,
    output logic [7:0]           done_count
);

    // One extra bit so ptr + offset can exceed N_REQ-1 before the modulo fold
    localparam int PW = ID_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    logic            resp_out_q;
    logic [7:0]      done_count_q;
    logic [7:0]      done_count_d;

    logic            grantFound;
    logic [ID_W-1:0] grantIdx;
    logic [PW-1:0]   scanIdx;
    logic            accept;

    logic [3:0]      selFunc;
    logic            selA;
    logic            selB;
    logic            gateOut;

    // Round-robin scan: walk offsets from highest to lowest so the requester
    // closest to the pointer (smallest offset) is the one left standing.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanIdx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scanIdx = {1'b0, ptr_q} + PW'(k);
            if (scanIdx >= PW'(N_REQ)) begin
                scanIdx = scanIdx - PW'(N_REQ);
            end
            if (req_valid[scanIdx[ID_W-1:0]]) begin
                grantFound = 1'b1;
                grantIdx   = scanIdx[ID_W-1:0];
            end
        end
    end

    // Accept only while idle; reset forces ready low even though the scan
    // would otherwise see pending requests at ptr 0.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && grantFound && !rst) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) && grantFound;

    // Steer the granted requester's truth table and operands onto the
    // shared evaluator inputs.
    always_comb begin
        selFunc = '0;
        selA    = 1'b0;
        selB    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                selFunc = req_func[4*i +: 4];
                selA    = req_a[i];
                selB    = req_b[i];
            end
        end
    end

    // The shared gate itself: a 4:1 mux whose data inputs are the truth
    // table and whose select lines are the operands.
    always_comb begin
        case ({selA, selB})
            2'b00:   gateOut = selFunc[0];
            2'b01:   gateOut = selFunc[1];
            2'b10:   gateOut = selFunc[2];
            default: gateOut = selFunc[3];
        endcase
    end

    // Next pointer lands just past the winner, folding back to 0 at the top.
    always_comb begin
        ptr_d        = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
        done_count_d = done_count_q + 8'd1;
    end

    // Sequencer: capture result on request handshake, hold it under
    // backpressure, and count completed responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_out_q   <= 1'b0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_id_q    <= grantIdx;
                        resp_out_q   <= gateOut;
                        ptr_q        <= ptr_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        done_count_q <= done_count_d;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_out   = resp_out_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_gate_lut_arbiter.sv
// tb_gate_lut_arbiter
// Drives gate_lut_arbiter from negedge-aligned stimulus, predicts each grant
// with an independent round-robin model and queues the expected {id,result}
// for comparison when the response is presented.

module tb_gate_lut_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_a;
    logic [N-1:0]       req_b;
    logic [4*N-1:0]     req_func;
    logic [N-1:0]       req_ready;
    logic               resp_valid;
    logic [ID_W-1:0]    resp_id;
    logic               resp_out;
    logic               resp_ready;
    logic [7:0]         done_count;

    logic [3:0]         tbFunc [N];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            out;
    } expResp_t;

    expResp_t           sbQueue [$];

    int                 assertCount = 0;
    int                 failCount   = 0;

    bit                 mState;
    int                 mPtr;
    logic [7:0]         mDone;

    logic [3:0]         xnorExp;
    logic [3:0]         rrExp;

    gate_lut_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_ready (resp_ready),
        .done_count (done_count)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack per-requester truth tables onto the flat function bus
    always_comb begin
        req_func = '0;
        for (int i = 0; i < N; i++) begin
            req_func[4*i +: 4] = tbFunc[i];
        end
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge
    task automatic resetDut();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_id",    32'(resp_id),    32'd0);
        checkOutput("rst_resp_out",   32'(resp_out),   32'd0);
        checkOutput("rst_done_count", 32'(done_count), 32'd0);
        checkOutput("rst_req_ready",  32'(req_ready),  32'd0);
        mState = 1'b0;
        mPtr   = 0;
        mDone  = 8'd0;
        sbQueue.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of checking: predict grant/response from the model, compare,
    // advance the model across the coming rising edge, land on next negedge
    task automatic stepCycle();
        logic [N-1:0] expReady;
        int           g;
        int           idx;
        logic [3:0]   f;
        logic [1:0]   ab;
        expResp_t     e;
        #1;
        checkOutput("done_count", 32'(done_count), 32'(mDone));
        if (!mState) begin
            expReady = '0;
            g        = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) begin
                expReady[g] = 1'b1;
                f    = tbFunc[g];
                ab   = {req_a[g], req_b[g]};
                e.id = ID_W'(g);
                e.out = f[ab];
                sbQueue.push_back(e);
                mPtr   = (g + 1) % N;
                mState = 1'b1;
            end
            checkOutput("req_ready",       32'(req_ready),  32'(expReady));
            checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
            checkOutput("resp_req_ready", 32'(req_ready),  32'd0);
            checkOutput("resp_valid",     32'(resp_valid), 32'd1);
            checkOutput("sb_pending",     32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                e = sbQueue[0];
                checkOutput("resp_id",  32'(resp_id),  32'(e.id));
                checkOutput("resp_out", 32'(resp_out), 32'(e.out));
                if (resp_ready) begin
                    void'(sbQueue.pop_front());
                    mState = 1'b0;
                    mDone  = mDone + 8'd1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Apply all directed scenarios in sequence
    task automatic applyStimulus();
        // Reset and idle
        resetDut();
        repeat (10) stepCycle();

        // XNOR sweep on requester 2
        resetDut();
        tbFunc[2]  = 4'b1001;
        resp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            req_valid = 4'b0100;
            req_a[2]  = n[1];
            req_b[2]  = n[0];
            stepCycle();
            req_valid = 4'b0000;
            checkOutput("xnor_id",  32'(resp_id),  32'd2);
            checkOutput("xnor_out", 32'(resp_out), 32'(xnorExp[n]));
            stepCycle();
        end
        checkOutput("xnor_done", 32'(done_count), 32'd4);

        // Round-robin with all requesters valid
        resetDut();
        tbFunc[0] = 4'b1000;
        tbFunc[1] = 4'b1110;
        tbFunc[2] = 4'b0110;
        tbFunc[3] = 4'b1001;
        req_a     = 4'b1111;
        req_b     = 4'b1111;
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            stepCycle();
            checkOutput("rr_id",  32'(resp_id),  32'(n % 4));
            checkOutput("rr_out", 32'(resp_out), 32'(rrExp[n % 4]));
            stepCycle();
        end
        req_valid = 4'b0000;
        checkOutput("rr_done", 32'(done_count), 32'd8);

        // Backpressure on requester 1
        resetDut();
        tbFunc[1]  = 4'b0110;
        req_a[1]   = 1'b1;
        req_b[1]   = 1'b0;
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        stepCycle();
        req_valid = 4'b1101;
        for (int n = 0; n < 5; n++) begin
            checkOutput("bp_id",   32'(resp_id),    32'd1);
            checkOutput("bp_out",  32'(resp_out),   32'd1);
            checkOutput("bp_done", 32'(done_count), 32'd0);
            stepCycle();
        end
        resp_ready = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("bp_next_id", 32'(resp_id), 32'd2);
        req_valid = 4'b0000;
        stepCycle();
        checkOutput("bp_done_final", 32'(done_count), 32'd2);

        // Pointer skip: ptr parked at 3, only 0 and 2 pending
        resetDut();
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        stepCycle();
        req_valid  = 4'b0000;
        stepCycle();
        req_valid  = 4'b0101;
        stepCycle();
        checkOutput("skip_id0", 32'(resp_id), 32'd0);
        req_valid  = 4'b0100;
        stepCycle();
        stepCycle();
        checkOutput("skip_id2", 32'(resp_id), 32'd2);
        req_valid  = 4'b0000;
        stepCycle();
        req_valid  = 4'b1111;
        stepCycle();
        checkOutput("skip_ptr3", 32'(resp_id), 32'd3);
        req_valid  = 4'b0000;
        stepCycle();

        // Reset while a response is pending
        resetDut();
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        stepCycle();
        req_valid  = 4'b1111;
        checkOutput("mrst_pending", 32'(resp_valid), 32'd1);
        resetDut();
        resp_ready = 1'b1;
        stepCycle();
        checkOutput("mrst_ptr0", 32'(resp_id), 32'd0);
        req_valid  = 4'b0000;
        stepCycle();
        checkOutput("mrst_done", 32'(done_count), 32'd1);

        // done_count wrap after 256 completions
        resetDut();
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        for (int n = 0; n < 256; n++) begin
            stepCycle();
            stepCycle();
            if (n == 254) checkOutput("wrap_255", 32'(done_count), 32'd255);
        end
        req_valid = 4'b0000;
        stepCycle();
        checkOutput("wrap_zero", 32'(done_count), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) tbFunc[i] = 4'b0000;
        xnorExp    = 4'b1001;
        rrExp      = 4'b1011;
        mState     = 1'b0;
        mPtr       = 0;
        mDone      = 8'd0;
        @(negedge clk);
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gate_lut_arbiter.md
# gate_lut_arbiter

Round-robin arbiter and sequencer that shares one mux-built 2-input logic evaluator between `N_REQ` requesters. Each request carries two operand bits and a 4-bit truth table selecting the gate function; for example, 4'b1001 is XNOR. The block grants one requester at a time, evaluates the gate through the 4:1 mux datapath, and returns the registered result with the requester ID on a valid/ready response channel. It sits between gate-level test/exercise logic and the shared mux-gate resource.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Legal range 2..8.
- `ID_W`, default 2: response ID width. Must equal $clog2(N_REQ).

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  N_REQ: bit i means requester i has a request.
- `req_a`  in  N_REQ: operand a of requester i.
- `req_b`  in  N_REQ: operand b of requester i.
- `req_func`  in  4*N_REQ: truth table of requester i, in bits [4i+3:4i]. Result = func[{a,b}].
- `req_ready`  out  N_REQ: one-hot or zero; bit i high means requester i is accepted this cycle.
- `resp_valid`  out  1: result available.
- `resp_id`  out  ID_W: index of the requester that owns the result.
- `resp_out`  out  1: gate result.
- `resp_ready`  in  1: consumer accepts the result.
- `done_count`  out  8: number of completed responses; wraps 255 -> 0.

## Operation
- FSM has two states, IDLE and RESP. Reset state is IDLE.
- Round-robin pointer `ptr` is ID_W bits; reset value 0.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
  - req_ready[g] is driven high combinationally in the same cycle; all other bits are low.
  - If no req_valid bit is set, req_ready is 0 and the FSM stays in IDLE.
- Handshake occurs on req_valid[g] & req_ready[g] at a rising edge. At that edge:
  - resp_id <= g.
  - resp_out <= req_func[4g + {req_a[g], req_b[g]}].
  - ptr <= (g+1) mod N_REQ.
  - State <= RESP.
- RESP:
  - resp_valid=1; req_ready is all 0.
  - resp_id and resp_out are held stable until the response handshake.
  - On resp_ready=1: state <= IDLE and done_count <= done_count+1.
  - If resp_ready stays low, the FSM stays in RESP indefinitely (backpressure).
- Exactly one request is outstanding at any time. A new grant is never issued in the cycle a response completes.
- Requests not granted must hold valid and operands. The arbiter does not latch operands of non-granted requesters.
- A requester that drops req_valid before being granted is simply skipped; this is not an error.
- The pointer advances only on an accepted request. An idle cycle never moves it.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_out=0, done_count=0, req_ready=0, ptr=0, state=IDLE.
- Reset is asynchronous and takes effect immediately, including mid-RESP. Any pending result is discarded and done_count is not incremented.
- Latency: a request accepted at edge T gives resp_valid=1 in the cycle after T. It is visible at T+1 when resp_ready is already high.
- Throughput: at most one result per 2 cycles, achieved only with resp_ready held high.
- req_ready depends combinationally on req_valid and ptr, only in IDLE. resp_* outputs are registered.
- Fairness: with all requesters continuously valid, grants follow 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 other grants.
- Wrap-around:
  - ptr wraps from N_REQ-1 to 0.
  - done_count wraps from 255 to 0 with no flag.

## Test plan
- Reset/idle: assert rst mid-cycle, then hold req_valid=0 for 10 cycles -> all outputs 0, req_ready=0, done_count=0 throughout.
- Single XNOR sweep: requester 2 only, func=4'b1001, {a,b}=00,01,10,11, resp_ready=1.
  - Results: resp_out=1,0,0,1.
  - resp_id=2 every time; done_count=4.
  - Each result appears 1 cycle after its accept.
- Round-robin: all 4 requesters valid continuously, funcs AND=4'b1000, OR=4'b1110, XOR=4'b0110, XNOR=4'b1001, a=b=1, over 8 grants.
  - resp_id sequence 0,1,2,3,0,1,2,3.
  - resp_out sequence 1,1,0,1 repeating.
- Backpressure: accept requester 1 (func=4'b0110, a=1, b=0), then hold resp_ready=0 for 5 cycles.
  - resp_valid=1, resp_id=1, resp_out=1 held stable.
  - req_ready=0 all 5 cycles; done_count unchanged until resp_ready=1.
- Pointer skip: ptr=3 (after granting 2); only requesters 0 and 2 valid -> grant 0 next, then 2. ptr after the two grants = 3.
- Reset mid-RESP and count wrap:
  - rst while resp_valid=1 -> resp_valid=0 immediately, ptr=0.
  - Separately, drive 256 completions -> done_count returns to 0.
